// File: rtl/rc4_pkg.sv
// rc4_pkg: shared mode/state types and plaintext classification for the key search sequencer
package rc4_pkg;

    typedef enum logic [2:0] {
        MODE_IDLE    = 3'b000,
        MODE_INIT    = 3'b001,
        MODE_SHUFFLE = 3'b010,
        MODE_DECRYPT = 3'b100
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHUFFLE,
        S_DECRYPT,
        S_GAP,
        S_EVAL,
        S_DONE
    } state_t;

    function automatic logic is_plain_char(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) || c == 8'h20;
    endfunction

    function automatic mode_t phase_mode(input state_t s);
        return s == S_SHUFFLE ? MODE_SHUFFLE : s == S_DECRYPT ? MODE_DECRYPT : s == S_INIT ? MODE_INIT : MODE_IDLE;
    endfunction

endpackage

// File: rtl/plaintext_checker.sv
// plaintext_checker: counts snooped result bytes and flags any byte outside 'a'..'z' / ' '
module plaintext_checker
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH      = 8,
    parameter int MESSAGE_LENGTH = 32,
    parameter int CNT_W          = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 aWren,
    input  logic [RAM_WIDTH-1:0] aIn,
    output logic                 bad,
    output logic [CNT_W-1:0]     cnt,
    output logic                 bad_now
);

    assign bad_now = aWren && !is_plain_char(8'(aIn));

    // Accumulate the bad flag and a byte count that saturates one past the expected length
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bad <= 1'b0;
            cnt <= '0;
        end else if (aWren) begin
            bad <= bad | bad_now;
            cnt <= cnt == CNT_W'(MESSAGE_LENGTH + 1) ? cnt : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_search_sequencer.sv
// key_search_sequencer: steps candidate RC4 keys through INIT/SHUFFLE/DECRYPT until a plaintext-looking result appears
module key_search_sequencer
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH          = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int KEY_SPACE_BITS     = 22,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5,
    parameter int NUM_DEVICES        = 3,
    parameter int KEY_START          = 0,
    parameter int KEY_STEP           = 1,
    parameter int EARLY_ABORT        = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic [NUM_DEVICES-1:0]               finish_bus,
    input  logic                                 aWren,
    input  logic [RAM_WIDTH-1:0]                 aIn,
    output logic [2:0]                           mode,
    output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key,
    output logic                                 busy,
    output logic                                 found,
    output logic                                 failed
);

    localparam int CNT_W = MESSAGE_LOG_LENGTH + 1;
    localparam int KW    = KEY_LENGTH * RAM_WIDTH;

    state_t                    state;
    state_t                    nxt;
    logic [KEY_SPACE_BITS-1:0] key_cnt;
    logic [KEY_SPACE_BITS:0]   key_nxt;
    logic                      bad;
    logic                      bad_now;
    logic [CNT_W-1:0]          cnt;

    assign key_nxt = {1'b0, key_cnt} + (KEY_SPACE_BITS + 1)'(KEY_STEP);
    assign key     = KW'(key_cnt);

    plaintext_checker #(
        .RAM_WIDTH(RAM_WIDTH),
        .MESSAGE_LENGTH(MESSAGE_LENGTH),
        .CNT_W(CNT_W)
    ) u_checker (
        .clk(clk),
        .reset(reset),
        .clear(state != S_DECRYPT),
        .aWren(aWren),
        .aIn(aIn),
        .bad(bad),
        .cnt(cnt),
        .bad_now(bad_now)
    );

    // Phase sequencing, key stepping and sticky result flags; stop overrides any phase completion
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            nxt     <= S_IDLE;
            mode    <= MODE_IDLE;
            key_cnt <= KEY_SPACE_BITS'(KEY_START);
            busy    <= 1'b0;
            found   <= 1'b0;
            failed  <= 1'b0;
        end else if (stop && busy) begin
            state <= S_IDLE;
            mode  <= MODE_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    found   <= 1'b0;
                    failed  <= 1'b0;
                    key_cnt <= KEY_SPACE_BITS'(KEY_START);
                    state   <= S_INIT;
                    mode    <= MODE_INIT;
                    busy    <= 1'b1;
                end
                S_INIT: if (finish_bus[0]) begin
                    state <= S_GAP;
                    nxt   <= S_SHUFFLE;
                    mode  <= MODE_IDLE;
                end
                S_SHUFFLE: if (finish_bus[1]) begin
                    state <= S_GAP;
                    nxt   <= S_DECRYPT;
                    mode  <= MODE_IDLE;
                end
                S_DECRYPT: if (finish_bus[2] || (EARLY_ABORT != 0 && (bad || bad_now))) begin
                    state <= S_EVAL;
                    mode  <= MODE_IDLE;
                end
                S_GAP: begin
                    state <= nxt;
                    mode  <= phase_mode(nxt);
                end
                S_EVAL: if (!bad && cnt == CNT_W'(MESSAGE_LENGTH)) begin
                    state <= S_DONE;
                    found <= 1'b1;
                    busy  <= 1'b0;
                end else if (key_nxt[KEY_SPACE_BITS]) begin
                    state  <= S_DONE;
                    failed <= 1'b1;
                    busy   <= 1'b0;
                end else begin
                    key_cnt <= key_nxt[KEY_SPACE_BITS-1:0];
                    state   <= S_INIT;
                    mode    <= MODE_INIT;
                end
                default: begin
                    state <= S_IDLE;
                    mode  <= MODE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
